// File: rtl/alu_seq.sv
// Registered ALU with eight logic/arith ops, barrel shifts and an iterative shift-add multiply.
// Single-cycle ops complete at the issuing edge; MUL takes WIDTH cycles behind a busy flag.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_NOTA = 4'd0;
  localparam logic [3:0] OP_NOTB = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_LSL  = 4'd8;
  localparam logic [3:0] OP_LSR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] result_next;
  logic             c_next, n_next, z_next, v_next, done_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0] mcand, mcand_next;
  logic [WIDTH-1:0] mplier, mplier_next;
  logic [SHW:0]     count, count_next;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_ext;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   lsl_ext, lsr_ext, asr_ext;
  logic signed [WIDTH:0] asr_src;
  logic [WIDTH-1:0] mul_sum;

  // Single-cycle datapath; shifts carry one guard bit so the last bit shifted out lands in it.
  always_comb begin
    b_eff   = (op == OP_SUB) ? ~b : b;
    add_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    shamt   = b[SHW-1:0];
    lsl_ext = {1'b0, a} << shamt;
    lsr_ext = {a, 1'b0} >> shamt;
    asr_src = $signed({a, 1'b0});
    asr_ext = $unsigned(asr_src >>> shamt);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_NOTA: alu_res = ~a;
      OP_NOTB: alu_res = ~b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_XNOR: alu_res = ~(a ^ b);
      OP_ADD, OP_SUB: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_LSL: begin
        alu_res = lsl_ext[WIDTH-1:0];
        alu_c   = lsl_ext[WIDTH];
      end
      OP_LSR: begin
        alu_res = lsr_ext[WIDTH:1];
        alu_c   = lsr_ext[0];
      end
      OP_ASR: begin
        alu_res = asr_ext[WIDTH:1];
        alu_c   = asr_ext[0];
      end
      default: alu_res = '0;
    endcase
  end

  assign mul_sum = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    state_next  = state;
    result_next = result;
    c_next      = c;
    n_next      = n;
    z_next      = z;
    v_next      = v;
    done_next   = 1'b0;
    acc_next    = acc;
    mcand_next  = mcand;
    mplier_next = mplier;
    count_next  = count;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_next  = a;
            mplier_next = b;
            acc_next    = '0;
            count_next  = (SHW + 1)'(WIDTH);
            state_next  = MUL;
          end else begin
            result_next = alu_res;
            c_next      = alu_c;
            v_next      = alu_v;
            n_next      = alu_res[WIDTH-1];
            z_next      = (alu_res == '0);
            done_next   = 1'b1;
          end
        end
      end
      MUL: begin
        acc_next    = mul_sum;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        count_next  = count - 1'b1;
        if (count == (SHW + 1)'(1)) begin
          result_next = mul_sum;
          c_next      = 1'b0;
          v_next      = 1'b0;
          n_next      = mul_sum[WIDTH-1];
          z_next      = (mul_sum == '0);
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      c      <= 1'b0;
      n      <= 1'b0;
      z      <= 1'b0;
      v      <= 1'b0;
      done   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      result <= result_next;
      c      <= c_next;
      n      <= n_next;
      z      <= z_next;
      v      <= v_next;
      done   <= done_next;
      acc    <= acc_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      count  <= count_next;
    end
  end

  assign busy = (state == MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: issued ops push model results, a negedge monitor checks each done.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        c, n, z, v, busy, done;

  typedef struct {
    logic [31:0] res;
    logic        c, n, z, v;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .c(c), .n(n), .z(z), .v(v), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cycle);
    end
  endtask

  // Reference model written directly from the arithmetic meaning of each op.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint unsigned ux = x, uy = y, s;
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint sr;
    int sh = int'(y & 32'd31);
    e.res = 0; e.c = 0; e.v = 0; e.cyc = 0;
    case (o)
      0: e.res = ~x;
      1: e.res = ~y;
      2: e.res = x & y;
      3: e.res = x | y;
      4: e.res = x ^ y;
      5: e.res = ~(x ^ y);
      6: begin
        s = ux + uy; e.res = s[31:0]; e.c = s[32];
        sr = sx + sy; e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      7: begin
        s = ux + (uy ^ 64'hFFFFFFFF) + 1; e.res = s[31:0]; e.c = s[32];
        sr = sx - sy; e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      8: begin e.res = x << sh; e.c = (sh != 0) ? x[32-sh] : 1'b0; end
      9: begin e.res = x >> sh; e.c = (sh != 0) ? x[sh-1] : 1'b0; end
      10: begin e.res = $signed(x) >>> sh; e.c = (sh != 0) ? x[sh-1] : 1'b0; end
      11: begin s = ux * uy; e.res = s[31:0]; end
      default: e.res = 0;
    endcase
    e.n = e.res[31];
    e.z = (e.res == 0);
    return e;
  endfunction

  // Drives one issue for the next rising edge and records what should complete and when.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    e = model(o, x, y);
    e.cyc = cycle + 1 + ((o == 4'd11) ? 32 : 0);
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_mul(input logic [31:0] x, input logic [31:0] y, input bit ign);
    applyStimulus(4'd11, x, y);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      start = ign && (i == 4);
      if (ign && i == 4) begin op = 4'd6; a = 32'd1; b = 32'd1; end
      checkOutput("mul_busy", busy, 1);
    end
    @(negedge clk);
    checkOutput("mul_busy_end", busy, 0);
  endtask

  // Monitor: every done must match the oldest expectation; outputs may only move on done.
  initial begin : monitor
    exp_t e;
    logic [35:0] prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = {result, c, n, z, v};
      end else begin
        if (done) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_done", done, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("done_cycle", cycle, e.cyc);
            checkOutput("result", result, e.res);
            checkOutput("flags_cnzv", {c, n, z, v}, {e.c, e.n, e.z, e.v});
          end
        end else begin
          checkOutput("hold_without_done", {result, c, n, z, v}, prev);
        end
        prev = {result, c, n, z, v};
      end
    end
  end

  initial begin
    int k;
    int budget;
    logic [3:0] ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #3;
    checkOutput("reset_outputs", {result, c, n, z, v, busy, done}, 0);
    @(negedge clk);
    #2 reset = 1'b0;

    applyStimulus(4'd6, 32'h7FFFFFFF, 32'd1);
    idle();
    checkOutput("add_ovf_res", result, 32'h80000000);
    checkOutput("add_ovf_cnzv", {c, n, z, v}, 4'b0101);

    applyStimulus(4'd7, 32'd5, 32'd5);
    applyStimulus(4'd7, 32'd0, 32'd1);
    applyStimulus(4'd10, 32'h80000000, 32'h24);
    applyStimulus(4'd9, 32'h0000000F, 32'd2);
    applyStimulus(4'd8, 32'h12345678, 32'd0);
    idle();
    checkOutput("lsl0_res", result, 32'h12345678);

    run_mul(32'h00010000, 32'h00010003, 1'b1);
    checkOutput("mul_res", result, 32'h00030000);
    checkOutput("mul_done", done, 1);

    applyStimulus(4'd11, 32'hDEADBEEF, 32'h1234567);
    k = cycle + 1;
    idle();
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("mid_mul_reset", {result, c, n, z, v, busy, done}, 0);
    sb.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    applyStimulus(4'd6, 32'd2, 32'd3);
    idle();
    checkOutput("post_reset_add", result, 32'd5);

    applyStimulus(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(4'd2, 32'hF0F0F0F0, 32'hFF00FF00);
    applyStimulus(4'd5, 32'hAAAA5555, 32'h5555AAAA);
    applyStimulus(4'd0, 32'h00000000, 32'h0);
    applyStimulus(4'd1, 32'h0, 32'hFFFF0000);

    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (i % 7 == 0) ra = {ra[31], 31'h7FFFFFFF} ^ {32{ra[0]}};
      if (ro == 4'd11) run_mul(ra, rb, 1'b0);
      else applyStimulus(ro, ra, rb);
    end
    idle();

    budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 32-bit combinational ALU. It keeps the eight original operations and their c/n/z/v flag semantics, and adds barrel shifts and an iterative shift-add multiply. Operations are issued with a start/busy/done handshake, and result and flags are held in output registers. It sits between the datapath operand registers and the writeback stage of the multi-cycle CPU datapath.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two, minimum 4.
- SHW, log2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue request, sampled on the rising edge while idle.
- op  input  4  operation code, sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- result  output  WIDTH  registered result; holds until the next completion.
- c, n, z, v  output  1 each  registered flags; hold until the next completion.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when result and flags update.

## Operation
- Op codes 0–7 keep the original encoding:
  - 0 NOT a, 1 NOT b, 2 AND, 3 OR, 4 XOR, 5 XNOR.
  - 6 ADD: a+b.
  - 7 SUB: a+~b+1.
- Op code 8 LSL: a << b[SHW-1:0].
- Op code 9 LSR: a >> b[SHW-1:0], zero fill.
- Op code 10 ASR: a >> b[SHW-1:0], sign fill. Bits of b above SHW-1 are ignored for all shifts.
- Op code 11 MUL: low WIDTH bits of a*b (unsigned), computed by iterative shift-add, one bit per cycle.
- Op codes 12–15 are reserved: result 0, treated as a logic op for flags.
- Flag rules:
  - n = result[WIDTH-1]; z = (result == 0). These apply to every op.
  - ADD/SUB: c = carry out of the WIDTH-bit add, so SUB with no borrow gives c=1. v = signed overflow, i.e. the operand-sign/result-sign rule applied to a and the effective b.
  - Shifts: c = last bit shifted out; c=0 when the shift amount is 0. v=0.
  - Logic, MUL, reserved: c=0, v=0.
- States:
  - IDLE: start=1 with a single-cycle op (everything except 11) writes result/flags and pulses done at the same edge. The state stays IDLE.
  - IDLE: start=1 with op=11 latches a and b, loads the counter with WIDTH, clears the accumulator and moves to MUL.
  - MUL: each edge adds the shifted multiplicand to the accumulator if the current multiplier bit is 1, then shifts and decrements the counter.
  - MUL: when the counter reaches 1, that edge writes result/flags, pulses done and returns to IDLE.
- start is ignored while in MUL; no queuing and no error indication.
- reset, asserted at any time including mid-multiply, immediately forces IDLE. The in-flight operation is discarded.
- Reset value of every output: result=0, c=n=z=v=0, busy=0, done=0. Counter and accumulator are also 0.

## Timing
- Single-cycle ops:
  - start sampled at edge k; result/flags valid and done=1 from edge k until edge k+1; busy stays 0.
  - Back-to-back issues every cycle are allowed; done stays high on consecutive cycles.
- MUL:
  - start at edge k; busy=1 from edge k to edge k+WIDTH.
  - Result/flags update and done=1 at edge k+WIDTH; busy=0 at the same edge.
  - Latency is WIDTH cycles.
  - A new start is first accepted at edge k+WIDTH+1 (sampled when state is IDLE).
- done is never high for more than one cycle per completed operation.
- result and flags change only on a done edge or on reset.
- Operands a/b/op may change freely while busy; the multiply uses its latched copies.

## Test plan
- ADD overflow (WIDTH=32): a=0x7FFFFFFF, b=1, op=6 -> result 0x80000000, n=1, v=1, c=0, z=0, done one cycle after start.
- SUB equal: a=5, b=5, op=7 -> result 0, z=1, c=1, v=0, n=0. Then a=0, b=1, op=7 -> result 0xFFFFFFFF, c=0, n=1.
- Shifts:
  - a=0x80000000, b=0x24, op=10 (amount 4; upper bits ignored) -> result 0xF8000000, c=0, n=1.
  - a=0x0000000F, b=2, op=9 -> result 0x3, c=1.
  - b=0, op=8 -> result=a, c=0.
- MUL with ignored start: a=0x00010000, b=0x00010003, op=11 -> busy high for 32 cycles, then result 0x00030000 with done at edge k+32, c=v=0. A second start at edge k+5 with op=6 is ignored; result and flags do not change before k+32.
- Reset mid-multiply: assert reset asynchronously at cycle 10 of a MUL -> all outputs 0 and busy=0 immediately. After release, ADD a=2, b=3 -> result 5 one cycle later.
- Reserved op: op=13, a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0, z=1, c=v=n=0. Four single-cycle starts on consecutive cycles -> four consecutive done cycles with matching results.
